udl_mod_counter: RTL
====================

Name: udl_mod_counter

Overview:
Parametrised up/down/load counter with a run-time modulus, programmable step, wrap or saturate mode, and a terminal-count pulse. It is the general-purpose counting primitive for the UART datapath: baud-tick dividers, bit counters, and oversampling counters. It adds these features to the plain up/down/load counter: a bounded range 0..limit, step greater than 1, a synchronous clear, a boundary strobe, and status flags.

Parameters:
BITS, 8, width of count, limit, step and load data

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous reset, active-high
enable  input  1  count enable; gates counting only
up  input  1  1 = count up, 0 = count down
load  input  1  synchronous parallel load; not gated by enable
clear  input  1  synchronous clear to 0; not gated by enable
sat  input  1  1 = saturate at boundaries, 0 = wrap (modulo limit+1)
limit  input  BITS  maximum count value; range is 0..limit
step  input  BITS  increment/decrement amount per enabled cycle
D  input  BITS  load data
Q  output  BITS  registered count
tc  output  1  registered terminal-count strobe
at_zero  output  1  combinational, Q == 0
at_max  output  1  combinational, Q == limit

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset value: Q = 0 and tc = 0. This gives at_zero = 1, and at_max = (limit == 0).
- Priority per rising edge, highest first: reset > clear > load > (enable & count) > hold.
- clear: Q <= 0, tc <= 0.
- load: Q <= min(D, limit), tc <= 0.
- Hold (enable = 0 and no load/clear/reset): Q unchanged, tc <= 0.
- All arithmetic is done in BITS+1 bits, so there is no silent overflow at the 2^BITS boundary.
- Count up, with sum = Q + step:
  - If sum <= limit: Q <= sum, tc <= 0.
  - Else, wrap mode (sat = 0): w = sum - (limit+1). Q <= w if w <= limit, else Q <= 0. tc <= 1.
  - Else, saturate mode (sat = 1): Q <= limit, tc <= 1.
- Count down:
  - If Q >= step: Q <= Q - step, tc <= 0. This holds even when Q > limit; no clamp is applied.
  - Else, wrap mode: Q <= Q + (limit+1) - step. If that result is > limit, Q <= 0. tc <= 1.
  - Else, saturate mode: Q <= 0, tc <= 1.
- Saturate mode: every enabled step that would cross the boundary re-asserts tc. Holding at the boundary with enable = 1 therefore keeps tc high each cycle.
- step = 0: Q holds and tc <= 0. This is the case even at a boundary.
- tc timing: tc is registered and rises on the same edge that writes the wrapped or saturated Q. It is a one-cycle pulse unless the boundary crossing repeats.
- limit changed below the current Q: the next up-count takes the sum > limit path. The next down-count subtracts normally.
- Wrap results are exact modulo (limit+1) only when step <= limit+1. Larger steps are legal, but the result follows the force-to-0 rule above.
- limit = 0:
  - Wrap mode: every enabled step with step > 0 gives Q = 0 and tc = 1.
  - Saturate mode: Q stays 0 and tc = 1 on each enabled step with step > 0.
- Reset mid-operation: Q = 0 and tc = 0 on the next edge, regardless of load, clear or enable.
- up, sat, limit and step are sampled only on enabled counting edges. No internal copy of them is kept.

Test Plan (BITS = 4):
1. Reset with load = 1, D = 5 → Q = 0, tc = 0, at_zero = 1. Deassert reset; load = 1, D = 5 → Q = 5 next edge.
2. Up, wrap mode, limit = 9, step = 1, start Q = 0, enable for 10 edges → Q = 1..9, then 0. tc = 1 only on the edge where Q becomes 0. at_max = 1 while Q = 9.
3. Up with step, wrap mode, limit = 11, Q = 10, step = 5 → Q = 3, tc = 1. Then with step = 0 → Q = 3, tc = 0.
4. Down with step, limit = 9, Q = 1, step = 3:
   - sat = 0 → Q = 8, tc = 1.
   - Repeat from Q = 1 with sat = 1 → Q = 0, tc = 1, and tc stays 1 on a further enabled edge while Q stays 0.
5. Load clamp and priority, limit = 9:
   - load = 1, D = 14, enable = 0 → Q = 9.
   - Same edge with clear = 1 and load = 1 → Q = 0.
   - Same edge with load = 1 and enable = 1, up = 1 → Q = min(D, 9), with no count applied.
6. Saturate up, limit = 7, Q = 6, step = 4 → Q = 7, tc = 1. Then assert reset while enable = 1 → Q = 0, tc = 0 next edge.

Source files
------------

// File: rtl/udl_mod_counter.sv
// udl_mod_counter: up/down/load counter over 0..limit with programmable step,
// wrap or saturate at the boundaries, and a registered terminal-count strobe.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   enable, up        count enable and direction (1 = up)
//   load, D           parallel load of min(D, limit), not gated by enable
//   clear             synchronous clear to 0, not gated by enable
//   sat               1 = saturate at the boundaries, 0 = wrap modulo limit+1
//   limit, step       top of the count range and per-cycle step
//   Q, tc             registered count and boundary-crossing strobe
//   at_zero, at_max   combinational Q == 0 and Q == limit
module udl_mod_counter #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            up,
    input  logic            load,
    input  logic            clear,
    input  logic            sat,
    input  logic [BITS-1:0] limit,
    input  logic [BITS-1:0] step,
    input  logic [BITS-1:0] D,
    output logic [BITS-1:0] Q,
    output logic            tc,
    output logic            at_zero,
    output logic            at_max
);
    logic [BITS-1:0] q_q, q_d;
    logic            tc_q, tc_d;
    logic [BITS:0]   q_x, lim_x, stp_x, lim_p1, sum, wrap_up, wrap_dn;

    // One extra bit keeps q+step and q+limit+1 from overflowing.
    assign q_x     = {1'b0, q_q};
    assign lim_x   = {1'b0, limit};
    assign stp_x   = {1'b0, step};
    assign lim_p1  = lim_x + {{BITS{1'b0}}, 1'b1};
    assign sum     = q_x + stp_x;
    assign wrap_up = sum - lim_p1;
    // A step larger than limit+1 can make this negative; it then wraps to a
    // value above limit and is forced to 0 like any other out-of-range result.
    assign wrap_dn = q_x + lim_p1 - stp_x;

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (clear) begin
            q_d = '0;
        end else if (load) begin
            q_d = (D > limit) ? limit : D;
        end else if (enable && step != '0) begin
            if (up) begin
                tc_d = sum > lim_x;
                q_d  = !tc_d ? sum[BITS-1:0] :
                       sat   ? limit :
                       (wrap_up <= lim_x) ? wrap_up[BITS-1:0] : '0;
            end else begin
                tc_d = q_q < step;
                q_d  = !tc_d ? q_q - step :
                       sat   ? '0 :
                       (wrap_dn <= lim_x) ? wrap_dn[BITS-1:0] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q  <= '0;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign Q       = q_q;
    assign tc      = tc_q;
    assign at_zero = q_q == '0;
    assign at_max  = q_q == limit;
endmodule
